// File: rtl/gate_arbiter.sv
// gate_arbiter: arbitrates entry and exit lanes of a parking garage over one
// shared gate and keeps a saturating count of the cars inside.
// Optional build macro GATE_EXIT_PRIORITY_EN: when defined, an eligible exit
// always wins a tie against entry; otherwise ties alternate round-robin.
module gate_arbiter #(
    parameter int unsigned CAPACITY    = 40,
    parameter int unsigned OPEN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_pass,
    output logic       gate_open,
    output logic       grant_in,
    output logic       grant_out,
    output logic [5:0] nums,
    output logic       full
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    localparam logic [5:0] CAP   = 6'(CAPACITY);
    localparam logic [7:0] TLOAD = 8'(OPEN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [5:0] nums_q, nums_d;
    logic       pend_in_q, pend_in_d;
    logic       pend_out_q, pend_out_d;
    logic       last_exit_q, last_exit_d;
    logic       gate_open_q, gate_open_d;
    logic       grant_in_q, grant_in_d;
    logic       grant_out_q, grant_out_d;

    logic in_ok, out_ok, take_in, take_out, drop_out;

    // Next-state logic: lane selection, open-window timing, count update and pending flags
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        nums_d      = nums_q;
        last_exit_d = last_exit_q;
        take_in     = 1'b0;
        take_out    = 1'b0;

        in_ok    = pend_in_q && (nums_q < CAP);
        out_ok   = pend_out_q && (nums_q != 6'd0);
        // A pending exit with nobody inside can never be served, so drop it.
        drop_out = (state_q == IDLE) && (nums_q == 6'd0);

        case (state_q)
            IDLE: begin
                if (btn) begin
                    if (in_ok && out_ok) begin
`ifdef GATE_EXIT_PRIORITY_EN
                        take_out = 1'b1;
`else
                        take_in  = last_exit_q;
                        take_out = !last_exit_q;
`endif
                    end else begin
                        take_in  = in_ok;
                        take_out = out_ok;
                    end
                end
                if (take_in) begin
                    state_d     = OPEN_IN;
                    timer_d     = TLOAD;
                    last_exit_d = 1'b0;
                end else if (take_out) begin
                    state_d     = OPEN_OUT;
                    timer_d     = TLOAD;
                    last_exit_d = 1'b1;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (car_pass) begin
                    state_d = CLOSE;
                    timer_d = '0;
                    if (state_q == OPEN_IN) begin
                        if (nums_q < CAP) nums_d = nums_q + 6'd1;
                    end else begin
                        if (nums_q != 6'd0) nums_d = nums_q - 6'd1;
                    end
                end else if (timer_q == 8'd0) begin
                    state_d = CLOSE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant clears win over a request sampled at the same edge.
        pend_in_d  = (pend_in_q || entry_req) && !take_in;
        pend_out_d = (pend_out_q || exit_req) && !take_out && !drop_out;

        gate_open_d = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
        grant_in_d  = (state_d == OPEN_IN);
        grant_out_d = (state_d == OPEN_OUT);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            nums_q      <= '0;
            pend_in_q   <= 1'b0;
            pend_out_q  <= 1'b0;
            last_exit_q <= 1'b1;
            gate_open_q <= 1'b0;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            nums_q      <= nums_d;
            pend_in_q   <= pend_in_d;
            pend_out_q  <= pend_out_d;
            last_exit_q <= last_exit_d;
            gate_open_q <= gate_open_d;
            grant_in_q  <= grant_in_d;
            grant_out_q <= grant_out_d;
        end
    end

    assign gate_open = gate_open_q;
    assign grant_in  = grant_in_q;
    assign grant_out = grant_out_q;
    assign nums      = nums_q;
    assign full      = (nums_q == CAP);

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level reference model.
module tb_gate_arbiter;

    localparam int CAP = 40;
    localparam int OC  = 8;

    logic       clk = 1'b0;
    logic       reset, btn, entry_req, exit_req, car_pass;
    logic       gate_open, grant_in, grant_out, full;
    logic [5:0] nums;

    always #5 clk = ~clk;

    gate_arbiter #(.CAPACITY(CAP), .OPEN_CYCLES(OC)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .car_pass  (car_pass),
        .gate_open (gate_open),
        .grant_in  (grant_in),
        .grant_out (grant_out),
        .nums      (nums),
        .full      (full)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 entry window, 2 exit window, 3 closing.
    // m_left counts open cycles still available in the window.
    int m_mode, m_left, m_nums;
    bit m_pin, m_pout, m_last_exit;

    task automatic model_edge();
        bit gi, go, can_in, can_out, idle_empty;
        if (!reset) begin
            m_mode = 0; m_left = 0; m_nums = 0;
            m_pin = 0; m_pout = 0; m_last_exit = 1;
            return;
        end
        gi = 0; go = 0;
        can_in     = m_pin && (m_nums < CAP);
        can_out    = m_pout && (m_nums > 0);
        idle_empty = (m_mode == 0) && (m_nums == 0);
        case (m_mode)
            0: begin
                if (btn) begin
                    if (can_in && can_out) begin
`ifdef GATE_EXIT_PRIORITY_EN
                        go = 1;
`else
                        if (m_last_exit) gi = 1; else go = 1;
`endif
                    end else begin
                        gi = can_in;
                        go = can_out;
                    end
                    if (gi) begin m_mode = 1; m_left = OC; m_last_exit = 0; end
                    else if (go) begin m_mode = 2; m_left = OC; m_last_exit = 1; end
                end
            end
            1, 2: begin
                if (car_pass) begin
                    if (m_mode == 1 && m_nums < CAP) m_nums++;
                    if (m_mode == 2 && m_nums > 0) m_nums--;
                    m_mode = 3;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 3;
                end
            end
            default: m_mode = 0;
        endcase
        m_pin  = (m_pin || entry_req) && !gi;
        m_pout = (m_pout || exit_req) && !go && !idle_empty;
    endtask

    task automatic compare_all();
        check_val("gate_open", gate_open, (m_mode == 1 || m_mode == 2));
        check_val("grant_in", grant_in, (m_mode == 1));
        check_val("grant_out", grant_out, (m_mode == 2));
        check_val("nums", nums, m_nums);
        check_val("full", full, (m_nums == CAP));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 0; entry_req = 0; exit_req = 0; car_pass = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic wait_open();
        for (int i = 0; i < 30 && !(m_mode == 1 || m_mode == 2); i++) tick();
        if (!(m_mode == 1 || m_mode == 2)) check_val("open_wait", gate_open, 1);
    endtask

    // Run out the current open window; pass_at selects the open cycle that
    // sees car_pass (0 = never). Returns how many cycles gate_open was seen high.
    task automatic finish_open(input int pass_at, output int open_seen);
        int k;
        k = 1;
        open_seen = (gate_open === 1'b1) ? 1 : 0;
        while ((m_mode == 1 || m_mode == 2) && k < 300) begin
            car_pass = (k == pass_at);
            tick();
            car_pass = 0;
            if (gate_open === 1'b1) open_seen++;
            k++;
        end
        tick();
    endtask

    task automatic run_txn(input bit lane_in, input int pass_at, output int open_seen);
        if (lane_in) entry_req = 1; else exit_req = 1;
        tick();
        entry_req = 0; exit_req = 0;
        wait_open();
        finish_open(pass_at, open_seen);
    endtask

    int cnt;

    initial begin
        btn = 1;
        do_reset();
        check_val("reset_nums", nums, 0);
        check_val("reset_gate", gate_open, 0);

        // Entry with car in third open cycle
        run_txn(1, 3, cnt);
        check_val("r028_open_cycles", cnt, 3);
        check_val("r028_nums", nums, 1);
        tick();

        // Window expiry without a car
        run_txn(1, 0, cnt);
        check_val("r030_open_cycles", cnt, OC);
        check_val("r030_nums", nums, 1);

        // Tie between lanes with nums=5 and last grant = exit
        do_reset();
        for (int i = 0; i < 6; i++) run_txn(1, 1, cnt);
        run_txn(0, 1, cnt);
        check_val("r029_pre_nums", nums, 5);
        entry_req = 1; exit_req = 1;
        tick();
        entry_req = 0; exit_req = 0;
        wait_open();
`ifdef GATE_EXIT_PRIORITY_EN
        check_val("r029_first_out", grant_out, 1);
`else
        check_val("r029_first_in", grant_in, 1);
`endif
        finish_open(1, cnt);
        wait_open();
`ifdef GATE_EXIT_PRIORITY_EN
        check_val("r029_second_in", grant_in, 1);
`else
        check_val("r029_second_out", grant_out, 1);
`endif
        finish_open(1, cnt);
        check_val("r029_nums", nums, 5);

        // Fill to capacity, blocked entry, then exit releases it
        do_reset();
        for (int i = 0; i < 50 && m_nums < CAP; i++) run_txn(1, 2, cnt);
        check_val("r031_full", full, 1);
        entry_req = 1;
        tick();
        entry_req = 0;
        for (int i = 0; i < 5; i++) tick();
        check_val("r031_no_grant", gate_open, 0);
        run_txn(0, 1, cnt);
        check_val("r031_nums", nums, CAP - 1);
        wait_open();
        check_val("r031_held_entry", grant_in, 1);
        finish_open(1, cnt);

        // Exit with empty garage, and entry while closed
        do_reset();
        exit_req = 1;
        tick();
        exit_req = 0;
        for (int i = 0; i < 4; i++) tick();
        check_val("r032_no_exit", gate_open, 0);
        btn = 0;
        entry_req = 1;
        tick();
        entry_req = 0;
        for (int i = 0; i < 5; i++) tick();
        check_val("r032_btn_hold", gate_open, 0);
        btn = 1;
        wait_open();
        check_val("r032_after_btn", grant_in, 1);
        finish_open(1, cnt);

        // Reset in the middle of an exit window
        do_reset();
        for (int i = 0; i < 3; i++) run_txn(1, 1, cnt);
        exit_req = 1;
        tick();
        exit_req = 0;
        wait_open();
        tick();
        check_val("r033_open", grant_out, 1);
        reset = 0;
        tick();
        check_val("r033_nums", nums, 0);
        check_val("r033_gate", gate_open, 0);
        reset = 1;
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) != 0);
            btn       = ($urandom_range(0, 9) != 0);
            entry_req = ($urandom_range(0, 2) == 0);
            exit_req  = ($urandom_range(0, 3) == 0);
            car_pass  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
